pipe_stage_elastic: RTL and testbench

//  Parametrised elastic pipeline stage between any two stages of the core (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - Carries a control field and a data payload with a valid/ready handshake.
//  - Supports synchronous flush; drained slots become bubbles with the control field zeroed.
//  - Counts downstream back-pressure cycles for performance analysis.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_sat_counter.sv | 24 ++
 rtl/pipe_stage_elastic.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for elastic pipeline stages.
// Ports: none (package only).
package pipe_pkg;

  localparam int PIPE_CTRL_W = 8;
  localparam int PIPE_DATA_W = 96;
  localparam int PIPE_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with async active-high reset.
// Ports: i_clk, i_rst, i_inc (count enable), o_cnt (value, holds at max).
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register with flush and stall counter.
// Ports: clk, reset (async high), flush (sync squash),
//   in_valid/in_ready/in_ctrl/in_data (upstream),
//   out_valid/out_ready/out_ctrl/out_data (downstream),
//   stall_cnt (saturating back-pressure cycle count).
// Define SKID_BUF_EN for a one-entry skid buffer with a registered in_ready.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_out_valid;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [DATA_W-1:0] r_out_data;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_stall;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_stall    = r_out_valid & ~out_ready;

`ifdef SKID_BUF_EN

  pipe_state_t       r_state;
  logic              r_in_ready;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  // in_ready comes straight from a flop: it drops only while the skid
  // slot is occupied, so out_ready never reaches it combinationally.
  assign in_ready = r_in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_data  <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_skid_ctrl <= '0;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_ctrl  <= in_ctrl;
            r_out_data  <= in_data;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_out_ctrl <= in_ctrl;
            r_out_data <= in_data;
          end else if (w_in_xfer) begin
            // Output is blocked: park the newer entry behind it.
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
            r_in_ready  <= 1'b0;
            r_state     <= ST_TWO;
          end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_xfer) begin
            r_out_ctrl  <= r_skid_ctrl;
            r_out_data  <= r_skid_data;
            r_skid_ctrl <= '0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_ctrl  <= '0;
        end
      endcase
    end
  end

`else

  assign in_ready = ~r_out_valid | out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_data  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
    end else if (w_in_xfer) begin
      r_out_valid <= 1'b1;
      r_out_ctrl  <= in_ctrl;
      r_out_data  <= in_data;
    end else if (w_out_xfer) begin
      // Payload is left in place; only control is squashed.
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
    end
  end

`endif

  assign out_valid = r_out_valid;
  assign out_ctrl  = r_out_ctrl;
  assign out_data  = r_out_data;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk (clk),
    .i_rst (reset),
    .i_inc (w_stall),
    .o_cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: directed cases plus random traffic.
// Ports: none (top-level bench).
module tb_pipe_stage_elastic;

  localparam int CW = 8;
  localparam int DW = 96;
  localparam int NW = 4;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt;

  ent_t sb[$];
  int   stall_m = 0;
  int   total = 0;
  int   bad = 0;

  pipe_stage_elastic #(
    .CTRL_W (CW),
    .DATA_W (DW),
    .CNT_W  (NW)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] a,
                     input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // Capacity view of the stage: one held entry in base mode, two with skid.
  function automatic logic model_ready();
`ifdef SKID_BUF_EN
    return sb.size() < 2;
`else
    return (sb.size() == 0) || out_ready;
`endif
  endfunction

  function automatic logic [DW-1:0] rd();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Monitor: compare presented output with scoreboard head, then retire.
  always @(negedge clk) begin
    logic v;
    #3;
    if (!rst) begin
      v = (sb.size() != 0);
      chk("out_valid", out_valid, v);
      if (v) begin
        chk("out_ctrl", out_ctrl, sb[0].c);
        chk("out_data", out_data, sb[0].d);
      end else begin
        chk("ctrl_zero", out_ctrl, '0);
      end
      chk("in_ready", in_ready, model_ready());
      chk("stall_cnt", stall_cnt, stall_m);
      if (v && !out_ready && stall_m != (1 << NW) - 1) stall_m++;
      if (flush) sb.delete();
      else if (v && out_ready) void'(sb.pop_front());
    end
  end

  task automatic cyc(input logic iv, input logic [CW-1:0] c,
                     input logic [DW-1:0] d, input logic ordy,
                     input logic fl);
    logic acc;
    @(negedge clk);
    #1;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    acc = iv && !fl && model_ready();
    #3;
    if (acc) sb.push_back('{c, d});
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ctrl", out_ctrl, '0);
    chk("rst_data", out_data, '0);
    chk("rst_stall", stall_cnt, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    sb.delete();
    stall_m   = 0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Back-to-back stream.
    for (int i = 1; i <= 4; i++) cyc(1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
    repeat (2) cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Back-pressure: one held entry, five stalled cycles.
    cyc(1'b1, 8'h11, 96'hA, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++)
      cyc(1'b1, CW'(8'h20 + k), DW'(96'hB0 + k), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("stall_five", stall_cnt, 4'd5);
    chk("held_data", out_data, 96'hA);
    repeat (4) cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush drops the offered entry.
    cyc(1'b1, 8'h33, rd(), 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, rd(), 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ctrl", out_ctrl, '0);
    repeat (2) cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Reset while an entry is held.
    cyc(1'b1, 8'h44, rd(), 1'b0, 1'b0);
    cyc(1'b1, 8'h45, rd(), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1'b1);
    do_reset();

    // Saturation of the 4-bit stall counter.
    cyc(1'b1, 8'h55, rd(), 1'b0, 1'b0);
    repeat (20) cyc(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("sat", stall_cnt, 4'hF);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("sat_after_flush", stall_cnt, 4'hF);
    chk("sat_flush_valid", out_valid, 1'b0);
    do_reset();

    // Random traffic.
    for (int n = 0; n < 10000; n++)
      cyc($urandom_range(0, 9) < 7, CW'($urandom), rd(),
          $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
    repeat (3) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
